// File: rtl/trace_pkg.sv
// Shared types and constants for the commit-trace datapath.
package trace_pkg;

   localparam int unsigned VLEN    = 64;
   localparam int unsigned XLEN    = 64;
   localparam int unsigned STAMP_W = 32;

   // mcause value for a breakpoint, mirrored from the core's riscv package
   localparam logic [XLEN-1:0] CAUSE_BREAKPOINT = 64'd3;

   typedef enum logic {
      TRC_COMMIT    = 1'b0,
      TRC_EXCEPTION = 1'b1
   } trace_kind_e;

   typedef struct packed {
      trace_kind_e         kind;
      logic [STAMP_W-1:0]  stamp;
      logic [1:0]          priv;
      logic [VLEN-1:0]     pc;
      logic [31:0]         instr;
      logic [4:0]          rd;
      logic [XLEN-1:0]     data0;
      logic [XLEN-1:0]     data1;
   } trace_record_t;

endpackage

// File: rtl/trace_mw_fifo.sv
// Multi-lane write, single FWFT read record buffer. Enabled lanes are packed
// contiguously in lane order starting at the write pointer.
module trace_mw_fifo
   import trace_pkg::*;
#(
   parameter int unsigned LANES = 3,
   parameter int unsigned DEPTH = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [LANES-1:0]            wr_en_i,
   input  trace_record_t [LANES-1:0]   wr_data_i,
   input  logic                        rd_ready_i,
   output logic                        rd_valid_o,
   output trace_record_t               rd_data_o,
   output logic [$clog2(DEPTH):0]      usage_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned UW = AW + 1;

   trace_record_t                mem_q [DEPTH];
   logic [AW-1:0]                wptr_q, wptr_d;
   logic [AW-1:0]                rptr_q, rptr_d;
   logic [UW-1:0]                usage_q, usage_d;
   logic [UW-1:0]                n_push;
   logic [LANES-1:0][AW-1:0]     slot;
   logic                         pop;

   // Prefix count of enabled lanes gives each lane its compacted slot
   always_comb begin
      n_push = '0;
      slot   = '0;
      for (int unsigned j = 0; j < LANES; j++) begin
         slot[j] = wptr_q + AW'(n_push);
         if (wr_en_i[j]) begin
            n_push = n_push + UW'(1);
         end
      end
      pop     = (usage_q != '0) && rd_ready_i;
      wptr_d  = wptr_q + AW'(n_push);
      rptr_d  = rptr_q + AW'(pop);
      usage_d = usage_q + n_push - UW'(pop);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         usage_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         usage_q <= usage_d;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned j = 0; j < LANES; j++) begin
         if (wr_en_i[j]) begin
            mem_q[slot[j]] <= wr_data_i[j];
         end
      end
   end

   // Head is forced to zero while empty so stale entries never leak out
   assign rd_valid_o = (usage_q != '0);
   assign rd_data_o  = rd_valid_o ? mem_q[rptr_q] : '0;
   assign usage_o    = usage_q;

endmodule

// File: rtl/trace_commit_sequencer.sv
// Serialises per-cycle commit/exception events into a record buffer drained
// one record per cycle to a valid/ready trace sink; drops whole cycles on overflow.
module trace_commit_sequencer
   import trace_pkg::*;
#(
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned DEPTH           = 8
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  trace_en_i,
   input  logic                                  clear_i,
   input  logic                                  debug_mode_i,
   input  logic [1:0]                            priv_lvl_i,
   input  logic [NR_COMMIT_PORTS-1:0]            commit_valid_i,
   input  logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]  commit_pc_i,
   input  logic [NR_COMMIT_PORTS-1:0][31:0]      commit_instr_i,
   input  logic [NR_COMMIT_PORTS-1:0][4:0]       commit_rd_i,
   input  logic [NR_COMMIT_PORTS-1:0][63:0]      commit_wdata_i,
   input  logic                                  exc_valid_i,
   input  logic [VLEN-1:0]                       exc_pc_i,
   input  logic [63:0]                           exc_cause_i,
   input  logic [63:0]                           exc_tval_i,
   output logic                                  out_valid_o,
   input  logic                                  out_ready_i,
   output trace_record_t                         out_record_o,
   output logic [$clog2(DEPTH):0]                usage_o,
   output logic [STAMP_W-1:0]                    drop_cnt_o,
   output logic                                  overflow_o
);

   localparam int unsigned LANES = NR_COMMIT_PORTS + 1;
   localparam int unsigned UW    = $clog2(DEPTH) + 1;
   localparam int unsigned KW    = $clog2(LANES + 1);
   localparam int unsigned DW    = STAMP_W + 1;

   logic [STAMP_W-1:0]          stamp_q, stamp_d;
   logic [STAMP_W-1:0]          drop_cnt_q, drop_cnt_d;
   logic                        overflow_q, overflow_d;
   logic [LANES-1:0]            cand_v;
   trace_record_t [LANES-1:0]   cand_rec;
   logic [LANES-1:0]            wr_en;
   logic [KW-1:0]               k;
   logic [UW-1:0]               free;
   logic [UW-1:0]               usage;
   logic                        admit;
   logic [DW-1:0]               drop_sum;

   // Candidate records: commit ports in port order, then the exception lane
   always_comb begin
      cand_v   = '0;
      cand_rec = '0;
      for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
         cand_v[i]         = trace_en_i && commit_valid_i[i];
         cand_rec[i].kind  = TRC_COMMIT;
         cand_rec[i].stamp = stamp_q;
         cand_rec[i].priv  = priv_lvl_i;
         cand_rec[i].pc    = commit_pc_i[i];
         cand_rec[i].instr = commit_instr_i[i];
         cand_rec[i].rd    = commit_rd_i[i];
         cand_rec[i].data0 = commit_wdata_i[i];
      end
      cand_v[LANES-1] = trace_en_i && exc_valid_i &&
                        !(debug_mode_i && (exc_cause_i == CAUSE_BREAKPOINT));
      cand_rec[LANES-1].kind  = TRC_EXCEPTION;
      cand_rec[LANES-1].stamp = stamp_q;
      cand_rec[LANES-1].priv  = priv_lvl_i;
      cand_rec[LANES-1].pc    = exc_pc_i;
      cand_rec[LANES-1].data0 = exc_cause_i;
      cand_rec[LANES-1].data1 = exc_tval_i;
   end

   // All-or-nothing admission against start-of-cycle occupancy
   always_comb begin
      k = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         k = k + KW'(cand_v[i]);
      end
      free       = UW'(DEPTH) - usage;
      admit      = (free >= UW'(k));
      wr_en      = admit ? cand_v : '0;
      drop_sum   = {1'b0, drop_cnt_q} + DW'(k);
      stamp_d    = trace_en_i ? stamp_q + STAMP_W'(1) : stamp_q;
      drop_cnt_d = drop_cnt_q;
      overflow_d = overflow_q;
      if (!admit) begin
         drop_cnt_d = drop_sum[STAMP_W] ? '1 : drop_sum[STAMP_W-1:0];
         overflow_d = 1'b1;
      end
      if (clear_i) begin
         drop_cnt_d = '0;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stamp_q    <= '0;
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         stamp_q    <= stamp_d;
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   trace_mw_fifo #(
      .LANES (LANES),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_en_i    (wr_en),
      .wr_data_i  (cand_rec),
      .rd_ready_i (out_ready_i),
      .rd_valid_o (out_valid_o),
      .rd_data_o  (out_record_o),
      .usage_o    (usage)
   );

   assign usage_o    = usage;
   assign drop_cnt_o = drop_cnt_q;
   assign overflow_o = overflow_q;

endmodule
